// File: rtl/step_dir_gen.sv
// step_dir_gen: step/direction pulse generator for one CNC axis
module step_dir_gen #(
  parameter int PULSE_W   = 4,
  parameter int DIR_SETUP = 8
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic        sclr,
  input  logic [2:1]  addr,
  input  logic [1:0]  be,
  input  logic [15:0] wrdata,
  input  logic        write,
  input  logic        start,
  input  logic        abort,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        done,
  output logic [31:0] remaining
);
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  localparam logic [15:0] PW    = 16'(PULSE_W);
  localparam logic [15:0] DS    = 16'(DIR_SETUP);
  localparam logic [15:0] MIN_P = 16'(2 * PULSE_W);
  state_t      state;
  logic [31:0] steps;
  logic [15:0] period;
  logic        dir_cmd;
  logic [15:0] timer;
  logic        abort_pend;
  logic [15:0] low_len;
  logic        t_end;
  assign low_len = (period > MIN_P ? period : MIN_P) - PW;
  assign t_end   = timer == 16'd1;
  // config registers, byte-granular, frozen while a move is running
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      steps   <= '0;
      period  <= '0;
      dir_cmd <= 1'b0;
    end else if (sclr) begin
      steps   <= '0;
      period  <= '0;
      dir_cmd <= 1'b0;
    end else if (write && !busy) begin
      case (addr)
        2'd0: begin
          if (be[0]) steps[7:0]  <= wrdata[7:0];
          if (be[1]) steps[15:8] <= wrdata[15:8];
        end
        2'd1: begin
          if (be[0]) steps[23:16] <= wrdata[7:0];
          if (be[1]) steps[31:24] <= wrdata[15:8];
        end
        2'd2: begin
          if (be[0]) period[7:0]  <= wrdata[7:0];
          if (be[1]) period[15:8] <= wrdata[15:8];
        end
        default: if (be[0]) dir_cmd <= wrdata[0];
      endcase
    end
  end
  // move sequencer: dir setup, then high/low phases per step; a started pulse always completes
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      timer      <= '0;
      abort_pend <= 1'b0;
    end else if (sclr) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      timer      <= '0;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !abort) begin
          if (steps != '0) begin
            state      <= SETUP;
            busy       <= 1'b1;
            dir        <= dir_cmd;
            remaining  <= steps;
            timer      <= DS;
            abort_pend <= 1'b0;
          end else done <= 1'b1;
        end
        SETUP: if (abort) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (t_end) begin
          state <= HIGH;
          step  <= 1'b1;
          timer <= PW;
        end else timer <= timer - 16'd1;
        HIGH: if (t_end) begin
          step      <= 1'b0;
          remaining <= remaining - 32'd1;
          if (abort || abort_pend) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= LOW;
            timer <= low_len;
          end
        end else begin
          timer      <= timer - 16'd1;
          abort_pend <= abort_pend | abort;
        end
        LOW: if (abort || (t_end && remaining == '0)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (t_end) begin
          state <= HIGH;
          step  <= 1'b1;
          timer <= PW;
        end else timer <= timer - 16'd1;
      endcase
    end
  end
endmodule

// File: tb/tb_step_dir_gen.sv
// tb_step_dir_gen: scoreboard bench for step_dir_gen, one expected record per done pulse
module tb_step_dir_gen;
  typedef struct {
    int          n;
    int          len;
    int          peff;
    logic [31:0] rem;
    logic        dir;
  } exp_t;
  logic        clk = 0, aclr_n = 0, sclr = 0, write = 0, start = 0, abort = 0;
  logic [2:1]  addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wrdata = '0;
  logic        step, dir, busy, done;
  logic [31:0] remaining;
  int          vectors = 0, miscompares = 0;
  exp_t        q[$];
  step_dir_gen dut (
    .clk(clk), .aclr_n(aclr_n), .sclr(sclr), .addr(addr), .be(be), .wrdata(wrdata),
    .write(write), .start(start), .abort(abort), .step(step), .dir(dir), .busy(busy),
    .done(done), .remaining(remaining)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  // monitor: measures each move on the negedge and checks it against the queue head at done
  int   cyc = 0, b_start = 0, n_pulse = 0, first_rise = 0, last_rise = 0;
  int   sp_min = 0, sp_max = 0, w_min = 0, w_max = 0, s = 0, np = 0;
  logic busy_q = 0, step_q = 0, d0 = 0, dir_bad = 0;
  exp_t e;
  always @(negedge clk) begin
    cyc++;
    if (!aclr_n) begin
      busy_q = 0;
      step_q = 0;
    end else begin
      if (busy && !busy_q) begin
        b_start = cyc; n_pulse = 0; sp_min = 1000; sp_max = 0;
        w_min = 1000; w_max = 0; d0 = dir; dir_bad = 0;
      end
      if (busy && dir !== d0) dir_bad = 1;
      if (step && !step_q) begin
        if (n_pulse == 0) first_rise = cyc - b_start;
        else begin
          s = cyc - last_rise;
          if (s < sp_min) sp_min = s;
          if (s > sp_max) sp_max = s;
        end
        last_rise = cyc;
        n_pulse++;
      end
      if (!step && step_q) begin
        s = cyc - last_rise;
        if (s < w_min) w_min = s;
        if (s > w_max) w_max = s;
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          np = busy_q ? n_pulse : 0;
          chk("busy_len", busy_q ? cyc - b_start : 0, e.len);
          chk("pulses", np, e.n);
          chk("busy_at_done", {31'b0, busy}, 0);
          chk("remaining", remaining, e.rem);
          chk("dir", {31'b0, dir}, {31'b0, e.dir});
          if (busy_q) chk("dir_stable", {31'b0, dir_bad}, 0);
          if (np > 0) begin
            chk("first_rise", first_rise, 8);
            chk("width_min", w_min, 4);
            chk("width_max", w_max, 4);
          end
          if (np > 1) begin
            chk("spacing_min", sp_min, e.peff);
            chk("spacing_max", sp_max, e.peff);
          end
        end
      end
      busy_q = busy;
      step_q = step;
    end
  end
  task automatic wr(logic [2:1] a, logic [1:0] b, logic [15:0] d);
    @(negedge clk);
    addr = a; be = b; wrdata = d; write = 1;
    @(negedge clk);
    write = 0;
  endtask
  task automatic set_move(logic [31:0] n, logic [15:0] p, logic d);
    wr(2'd0, 2'b11, n[15:0]);
    wr(2'd1, 2'b11, n[31:16]);
    wr(2'd2, 2'b11, p);
    wr(2'd3, 2'b01, {15'b0, d});
  endtask
  task automatic go();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic pulse_abort();
    abort = 1;
    @(negedge clk);
    abort = 0;
  endtask
  task automatic drain(int max);
    for (int i = 0; i < max && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_edges(logic rising, int count);
    int   k = 0;
    logic p = step;
    for (int i = 0; i < 500 && k < count; i++) begin
      @(negedge clk);
      if (rising ? (step && !p) : (!step && p)) k++;
      p = step;
    end
    if (k < count) chk("edge_timeout", k, count);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_step", {31'b0, step}, 0);
    chk("rst_dir", {31'b0, dir}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_remaining", remaining, 0);
    aclr_n = 1;
    wr(2'd0, 2'b11, 16'h0203);
    wr(2'd1, 2'b11, 16'h0000);
    wr(2'd2, 2'b11, 16'd10);
    wr(2'd3, 2'b01, 16'd0);
    wr(2'd0, 2'b10, 16'h0000);
    q.push_back('{3, 38, 10, 0, 0});
    go();
    drain(200);
    set_move(2, 3, 0);
    q.push_back('{2, 24, 8, 0, 0});
    go();
    drain(200);
    set_move(2, 10, 1);
    q.push_back('{2, 28, 10, 0, 1});
    go();
    repeat (5) @(negedge clk);
    wr(2'd0, 2'b11, 16'd7);
    wr(2'd3, 2'b01, 16'd0);
    drain(200);
    q.push_back('{2, 28, 10, 0, 1});
    go();
    drain(200);
    set_move(0, 10, 0);
    q.push_back('{0, 0, 10, 0, 1});
    go();
    drain(10);
    set_move(100, 10, 0);
    q.push_back('{5, 52, 10, 95, 0});
    go();
    wait_edges(1, 5);
    pulse_abort();
    drain(200);
    set_move(10, 10, 1);
    q.push_back('{2, 23, 10, 8, 1});
    go();
    wait_edges(0, 2);
    pulse_abort();
    drain(200);
    set_move(5, 10, 0);
    q.push_back('{0, 1, 10, 5, 0});
    go();
    pulse_abort();
    drain(20);
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    repeat (3) @(negedge clk);
    chk("start_abort_busy", {31'b0, busy}, 0);
    chk("start_abort_rem", remaining, 5);
    set_move(3, 10, 1);
    go();
    wait_edges(1, 1);
    #2 aclr_n = 0;
    #1;
    chk("aclr_step", {31'b0, step}, 0);
    chk("aclr_dir", {31'b0, dir}, 0);
    chk("aclr_busy", {31'b0, busy}, 0);
    chk("aclr_remaining", remaining, 0);
    @(negedge clk);
    aclr_n = 1;
    q.push_back('{0, 0, 10, 0, 0});
    go();
    drain(10);
    set_move(2, 10, 0);
    q.push_back('{2, 28, 10, 0, 0});
    go();
    drain(200);
    set_move(4, 10, 1);
    go();
    repeat (12) @(negedge clk);
    sclr = 1;
    @(negedge clk);
    sclr = 0;
    chk("sclr_step", {31'b0, step}, 0);
    chk("sclr_dir", {31'b0, dir}, 0);
    chk("sclr_busy", {31'b0, busy}, 0);
    chk("sclr_remaining", remaining, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
